ext_bus_seq: RTL and testbench

- Sequences single external-bus transactions for the CPU core: address, chip select, read/write strobes and the 8-bit tristate data bus.
- Sits directly upstream of the bus-keeper cell on the data bus.
- Drives the bus only during write data phases and releases it to high-Z at all other times, so the keeper holds the last value.
- Samples read data at the end of each read cycle.

---
 rtl/ext_bus_pkg.sv | 16 +
 rtl/ext_bus_tristate_drv.sv | 15 +
 rtl/ext_bus_seq.sv | 124 ++++++++++++
 tb/tb_ext_bus_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the external-bus sequencer.
package ext_bus_pkg;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

  localparam int WAIT_CNT_W = 4;
  localparam int TXN_ADDR_W = 16;
  localparam int TXN_D_W    = 8;

  typedef struct packed {
    logic                  we;
    logic [TXN_ADDR_W-1:0] addr;
    logic [TXN_D_W-1:0]    wdata;
  } txn_t;

endpackage

// File: rtl/ext_bus_tristate_drv.sv
// Output-enable gated tristate driver for the external data bus, plus the
// input path used to sample read data.
module ext_bus_tristate_drv #(
  parameter int D_W = 8
) (
  input  logic           oe,
  input  logic [D_W-1:0] dout,
  output logic [D_W-1:0] din,
  inout  wire  [D_W-1:0] d_bus
);

  assign d_bus = oe ? dout : {D_W{1'bz}};
  assign din   = d_bus;

endmodule

// File: rtl/ext_bus_seq.sv
// External-bus transaction sequencer (IDLE/T1..T4) driving address, strobes and
// the tristate data bus. Optional simulation checks: EXT_BUS_CONTENTION_CHECK_EN.
module ext_bus_seq
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int D_W         = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [D_W-1:0]    wdata,
  output logic              ready,
  output logic              ack,
  output logic [D_W-1:0]    rdata,
  output logic [ADDR_W-1:0] a_bus,
  inout  wire  [D_W-1:0]    d_bus,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n
);

  if (ADDR_W != TXN_ADDR_W || D_W != TXN_D_W || WAIT_CYCLES < 0 || WAIT_CYCLES > 15)
  begin : g_cfg_err
    $error("ext_bus_seq: ADDR_W/D_W must match ext_bus_pkg, WAIT_CYCLES must be 0..15");
  end

  state_t                state_q, state_d;
  txn_t                  txn_q;
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic                  take;
  logic                  strobe_d;
  logic                  oe_q;
  logic [D_W-1:0]        d_in;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          take    = 1'b1;
          state_d = T1;
        end
      end
      T1: state_d = T2;
      T2: state_d = T3;
      T3: if (cnt_q == '0) state_d = T4;
      T4: begin
        if (req) begin
          take    = 1'b1;
          state_d = T1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    strobe_d = (state_d == T2) || (state_d == T3);
  end

  // Bus-side outputs are registered from the next-state decode so they change
  // cleanly on the clock edge that enters each phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_bus   <= '0;
      rdata   <= '0;
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) a_bus <= addr;
      if (state_q == T2)
        cnt_q <= WAIT_CNT_W'(WAIT_CYCLES);
      else if (state_q == T3 && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
      cs_n <= (state_d == IDLE);
      rd_n <= !(strobe_d && !txn_q.we);
      wr_n <= !(strobe_d && txn_q.we);
      oe_q <= strobe_d && txn_q.we;
      // Read data is taken on the last T3 edge while rd_n is still low.
      if (state_q == T3 && cnt_q == '0 && !txn_q.we) rdata <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      txn_q.we    <= we;
      txn_q.addr  <= addr;
      txn_q.wdata <= wdata;
    end
  end

  assign ready = (state_q == IDLE) || (state_q == T4);
  assign ack   = (state_q == T4);

  ext_bus_tristate_drv #(.D_W(D_W)) u_drv (
    .oe    (oe_q),
    .dout  (txn_q.wdata),
    .din   (d_in),
    .d_bus (d_bus)
  );

`ifdef EXT_BUS_CONTENTION_CHECK_EN
  always @(posedge clk) begin
    if (!reset) begin
      if ((state_q == T2 || state_q == T3) && txn_q.we && $isunknown(d_in))
        $error("ext_bus_seq: d_bus contention writing addr %h at %0t", txn_q.addr, $time);
      if (state_q == T3 && cnt_q == '0 && !txn_q.we && $isunknown(d_in))
        $warning("ext_bus_seq: undefined read data from addr %h at %0t", txn_q.addr, $time);
    end
  end
`else
  // Bus integrity checks are compiled out.
`endif

endmodule

// File: tb/tb_ext_bus_seq.sv
// Scoreboard bench for ext_bus_seq: two instances (WAIT_CYCLES 0 and 3) with a
// simple memory device on each data bus and a timeline-based reference model.
module tb_ext_bus_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req, we, ready, ack, cs_n, rd_n, wr_n, oe_obs;
  logic [15:0] addr  [2];
  logic [7:0]  wdata [2];
  logic [7:0]  rdata [2];
  logic [15:0] a_bus [2];
  logic [7:0]  d_obs [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [7:0]  d;
    int          cap;
  } exp_t;

  exp_t        exp_q [2][$];
  logic [7:0]  ref_mem [2][65536];
  logic [7:0]  exp_rdata [2];

  function automatic int wait_of(int g);
    return (g == 0) ? 0 : 3;
  endfunction

  function automatic logic [7:0] init_val(logic [15:0] a);
    if (a == 16'h8000) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s[%0d] cyc %0d: got %0h expected %0h", nm, g, cyc, act, expv);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    wire  [7:0] d_bus;
    logic [7:0] mem [65536];
    logic       dev_oe;
    logic [7:0] dev_val;

    assign dev_oe   = !cs_n[g] && !rd_n[g];
    assign dev_val  = mem[a_bus[g]];
    assign d_bus    = dev_oe ? dev_val : 8'bz;
    assign d_obs[g] = d_bus;
    assign oe_obs[g] = u_dut.oe_q;

    ext_bus_seq #(.ADDR_W(16), .D_W(8), .WAIT_CYCLES(g == 0 ? 0 : 3)) u_dut (
      .clk   (clk),
      .reset (reset),
      .req   (req[g]),
      .we    (we[g]),
      .addr  (addr[g]),
      .wdata (wdata[g]),
      .ready (ready[g]),
      .ack   (ack[g]),
      .rdata (rdata[g]),
      .a_bus (a_bus[g]),
      .d_bus (d_bus),
      .cs_n  (cs_n[g]),
      .rd_n  (rd_n[g]),
      .wr_n  (wr_n[g])
    );

    // Memory device: stores on every clock edge seen with cs_n and wr_n low.
    initial begin
      for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
      forever begin
        @(posedge clk);
        if (!cs_n[g] && !wr_n[g]) mem[a_bus[g]] = d_obs[g];
      end
    end
  end

  // Monitor: expected pin state derived from each transaction's capture cycle.
  initial begin : mon
    bit   inf, strb, isack;
    int   off, w;
    exp_t f;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        w = wait_of(g);
        if (reset) begin
          exp_q[g].delete();
          exp_rdata[g] = '0;
        end
        inf = 1'b0;
        off = 0;
        if (exp_q[g].size() > 0 && cyc >= exp_q[g][0].cap) begin
          inf = 1'b1;
          f   = exp_q[g][0];
          off = cyc - f.cap;
        end
        strb  = inf && off >= 1 && off <= 2 + w;
        isack = inf && off == 3 + w;
        chk("cs_n",  g, 32'(cs_n[g]),   32'(!inf));
        chk("rd_n",  g, 32'(rd_n[g]),   32'(!(strb && !f.w)));
        chk("wr_n",  g, 32'(wr_n[g]),   32'(!(strb && f.w)));
        chk("drive", g, 32'(oe_obs[g]), 32'(strb && f.w));
        chk("ack",   g, 32'(ack[g]),    32'(isack));
        chk("ready", g, 32'(ready[g]),  32'(!inf || isack));
        if (inf) chk("a_bus", g, 32'(a_bus[g]), 32'(f.a));
        if (strb && f.w) chk("d_bus", g, 32'(d_obs[g]), 32'(f.d));
        if (!isack) chk("rdata", g, 32'(rdata[g]), 32'(exp_rdata[g]));
        if (isack) begin
          void'(exp_q[g].pop_front());
          if (!f.w) exp_rdata[g] = f.d;
        end
      end
    end
  end

  task automatic issue(int g, bit w, logic [15:0] a, logic [7:0] d, bit hold);
    exp_t e;
    int   n;
    req[g]   = 1'b1;
    we[g]    = w;
    addr[g]  = a;
    wdata[g] = d;
    n = 0;
    while (!ready[g] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!ready[g]) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout[%0d] cyc %0d: got ready 0 expected 1", g, cyc);
      req[g] = 1'b0;
      return;
    end
    e.w   = w;
    e.a   = a;
    e.d   = w ? d : ref_mem[g][a];
    e.cap = cyc + 1;
    if (w) ref_mem[g][a] = d;
    exp_q[g].push_back(e);
    @(negedge clk);
    if (!hold) req[g] = 1'b0;
  endtask

  task automatic wait_idle(int g);
    int n;
    n = 0;
    while (exp_q[g].size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[g].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout[%0d] cyc %0d: got %0d pending expected 0", g, cyc, exp_q[g].size());
    end
    @(negedge clk);
  endtask

  task automatic rand_run(int g);
    bit          w, hold;
    logic [15:0] a;
    logic [7:0]  d;
    for (int n = 0; n < 30; n++) begin
      w    = 1'($urandom_range(0, 1));
      a    = {12'hC00, 4'($urandom_range(0, 15))};
      d    = 8'($urandom);
      hold = (n < 29) && ($urandom_range(0, 2) == 0);
      issue(g, w, a, d, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(g);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc %0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    we    = '0;
    for (int g = 0; g < 2; g++) begin
      addr[g]  = '0;
      wdata[g] = '0;
      for (int i = 0; i < 65536; i++) ref_mem[g][i] = init_val(16'(i));
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_rdata", g, 32'(rdata[g]), 32'h0);
      chk("rst_a_bus", g, 32'(a_bus[g]), 32'h0);
      chk("rst_ack",   g, 32'(ack[g]),   32'h0);
      chk("rst_ready", g, 32'(ready[g]), 32'h1);
      chk("rst_strb",  g, 32'({cs_n[g], rd_n[g], wr_n[g]}), 32'h7);
      chk("rst_drive", g, 32'(oe_obs[g]), 32'h0);
    end
    reset = 1'b0;
    @(negedge clk);

    issue(0, 1'b0, 16'h8000, 8'h00, 1'b0);
    wait_idle(0);
    chk("read_8000", 0, 32'(rdata[0]), 32'hA5);
    issue(0, 1'b1, 16'hFF80, 8'h3C, 1'b0);
    wait_idle(0);
    issue(0, 1'b0, 16'hFF80, 8'h00, 1'b0);
    wait_idle(0);
    chk("read_ff80", 0, 32'(rdata[0]), 32'h3C);
    issue(0, 1'b1, 16'hC000, 8'h11, 1'b1);
    issue(0, 1'b0, 16'hC001, 8'h00, 1'b0);
    wait_idle(0);
    issue(1, 1'b0, 16'h0100, 8'h00, 1'b0);
    wait_idle(1);
    chk("read_0100", 1, 32'(rdata[1]), 32'(init_val(16'h0100)));

    fork
      rand_run(0);
      rand_run(1);
    join

    // Reset while instance 1 sits in write T3.
    issue(1, 1'b1, 16'h0200, 8'h77, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_wr_n",  1, 32'(wr_n[1]),   32'h1);
    chk("mid_drive", 1, 32'(oe_obs[1]), 32'h0);
    chk("mid_cs_n",  1, 32'(cs_n[1]),   32'h1);
    chk("mid_ack",   1, 32'(ack[1]),    32'h0);
    chk("mid_ready", 1, 32'(ready[1]),  32'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_ready", 1, 32'(ready[1]), 32'h1);
    issue(1, 1'b0, 16'h0200, 8'h00, 1'b0);
    wait_idle(1);
    chk("read_0200", 1, 32'(rdata[1]), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
